fetch_stage: RTL and testbench

//   First pipeline stage of the CPU core. Fetches instruction bytes from memory.

---
 rtl/cpu_pkg.sv | 24 ++
 rtl/fetch_stage_if.sv | 37 +++
 rtl/fetch_fifo.sv | 69 ++++++
 rtl/fetch_stage.sv | 130 +++++++++++++
 tb/tb_fetch_stage.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | cpu_pkg                                                                    |
// | Shared CPU-core types: address/data widths, fetch entry, fetch FSM states. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package cpu_pkg;

  localparam int CPU_ADDR_W = 16;
  localparam int CPU_DATA_W = 8;

  typedef struct packed {
    logic [CPU_ADDR_W-1:0] pc;
    logic [CPU_DATA_W-1:0] data;
  } fetch_entry_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_t;

endpackage
`default_nettype wire

// File: rtl/fetch_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_stage_if                                                             |
// | Memory read port, redirect input and decode-side valid/ready handshake.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
interface fetch_stage_if
  import cpu_pkg::*;
#(
  parameter int ADDR_W = CPU_ADDR_W,
  parameter int DATA_W = CPU_DATA_W
);

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_data;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [ADDR_W-1:0] out_pc;
  logic              out_ready;

  // master = the fetch stage, slave = memory / redirect source / decode
  modport master (
    output mem_req, mem_addr, out_valid, out_data, out_pc,
    input  mem_ack, mem_data, redirect, redirect_pc, out_ready
  );

  modport slave (
    input  mem_req, mem_addr, out_valid, out_data, out_pc,
    output mem_ack, mem_data, redirect, redirect_pc, out_ready
  );

endinterface
`default_nettype wire

// File: rtl/fetch_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_fifo                                                                 |
// | Synchronous FIFO of fetched {pc,data} entries; flush beats push.           |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fetch_fifo
  import cpu_pkg::*;
#(
  parameter int WIDTH = $bits(fetch_entry_t),
  parameter int DEPTH = 4
) (
  input  wire logic                    clk,
  input  wire logic                    rst,
  input  wire logic                    push,
  input  wire logic                    pop,
  input  wire logic                    flush,
  input  wire logic [WIDTH-1:0]        din,
  output logic      [$clog2(DEPTH):0]  count,
  output logic      [WIDTH-1:0]        head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] c_full = (PTR_W+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W:0]   r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_pop  = pop && (r_count != '0);
  // A simultaneous pop frees the slot, so a full FIFO can still accept a push
  assign w_do_push = push && ((r_count != c_full) || w_do_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_mem[r_wr_ptr] <= din;
        r_wr_ptr        <= r_wr_ptr + PTR_W'(1);
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign count = r_count;
  assign head  = r_mem[r_rd_ptr];

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fetch_stage                                                                |
// | Instruction fetch: PC, single-outstanding memory FSM, entry FIFO, redirect.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fetch_stage
  import cpu_pkg::*;
#(
  parameter int                ADDR_W     = CPU_ADDR_W,
  parameter int                DATA_W     = CPU_DATA_W,
  parameter int                FIFO_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input wire logic      clk,
  input wire logic      rst,
  fetch_stage_if.master bus
);

  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int ENTRY_W = ADDR_W + DATA_W;

  fetch_state_t       r_state;
  logic [ADDR_W-1:0]  r_pc;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic               r_mem_req;

  logic [ADDR_W-1:0]  w_pc_inc;
  logic [CNT_W-1:0]   w_count;
  logic [CNT_W-1:0]   w_occupancy;
  logic               w_issue_ok;
  logic               w_push;
  logic               w_pop;
  logic               w_out_valid;
  logic [ENTRY_W-1:0] w_head;

  assign w_pc_inc    = r_pc + ADDR_W'(1);
  assign w_out_valid = (w_count != '0);
  assign w_pop       = w_out_valid && bus.out_ready && !bus.redirect;
  assign w_push      = (r_state == ST_WAIT) && bus.mem_ack && !bus.redirect;

  // Buffered entries plus the outstanding request: every ack is guaranteed a slot
  assign w_occupancy = w_count + CNT_W'(r_mem_req);
  assign w_issue_ok  = (w_occupancy < CNT_W'(FIFO_DEPTH));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_pc       <= RESET_PC;
      r_mem_req  <= 1'b0;
      r_mem_addr <= RESET_PC;
    end else if (bus.redirect) begin
      r_pc <= bus.redirect_pc;
      case (r_state)
        ST_WAIT, ST_DROP: begin
          if (bus.mem_ack) begin
            r_state   <= ST_IDLE;
            r_mem_req <= 1'b0;
          end else begin
            // Old request must still complete; its data is thrown away
            r_state <= ST_DROP;
          end
        end
        default: begin
          r_state    <= ST_WAIT;
          r_mem_req  <= 1'b1;
          r_mem_addr <= bus.redirect_pc;
        end
      endcase
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_issue_ok) begin
            r_state    <= ST_WAIT;
            r_mem_req  <= 1'b1;
            r_mem_addr <= r_pc;
          end
        end
        ST_WAIT: begin
          if (bus.mem_ack) begin
            r_pc <= w_pc_inc;
            if (w_issue_ok) begin
              r_mem_addr <= w_pc_inc;
            end else begin
              r_state   <= ST_IDLE;
              r_mem_req <= 1'b0;
            end
          end
        end
        ST_DROP: begin
          if (bus.mem_ack) begin
            if (w_issue_ok) begin
              r_state    <= ST_WAIT;
              r_mem_addr <= r_pc;
            end else begin
              r_state   <= ST_IDLE;
              r_mem_req <= 1'b0;
            end
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_mem_req <= 1'b0;
        end
      endcase
    end
  end

  fetch_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .flush (bus.redirect),
    .din   ({r_pc, bus.mem_data}),
    .count (w_count),
    .head  (w_head)
  );

  assign bus.mem_req   = r_mem_req;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.out_valid = w_out_valid;
  assign bus.out_pc    = w_head[ENTRY_W-1:DATA_W];
  assign bus.out_data  = w_head[DATA_W-1:0];

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_fetch_stage                                                             |
// | Directed bench for fetch_stage with a latency-controlled memory model.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_fetch_stage;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_stage_if #(.ADDR_W(16), .DATA_W(8)) bus   ();
  fetch_stage_if #(.ADDR_W(16), .DATA_W(8)) bus_w ();

  fetch_stage #(.ADDR_W(16), .DATA_W(8), .FIFO_DEPTH(4), .RESET_PC(16'h0000)) dut (
    .clk (clk), .rst (rst), .bus (bus)
  );

  fetch_stage #(.ADDR_W(16), .DATA_W(8), .FIFO_DEPTH(4), .RESET_PC(16'hFFFE)) dut_w (
    .clk (clk), .rst (rst), .bus (bus_w)
  );

  // Memory for dut: acks once a request has waited mem_lat cycles, gated by mem_en
  logic       mem_en;
  int         mem_lat;
  logic [7:0] data_base;
  int         age;

  always @(posedge clk or posedge rst) begin
    if (rst)                               age <= 0;
    else if (!bus.mem_req || bus.mem_ack)  age <= 0;
    else                                   age <= age + 1;
  end

  assign bus.mem_ack  = bus.mem_req && mem_en && (age >= mem_lat);
  assign bus.mem_data = data_base + bus.mem_addr[7:0];

  assign bus_w.mem_ack     = bus_w.mem_req;
  assign bus_w.mem_data    = bus_w.mem_addr[7:0];
  assign bus_w.redirect    = 1'b0;
  assign bus_w.redirect_pc = 16'h0000;
  assign bus_w.out_ready   = 1'b1;

  logic [23:0] got   [$];
  logic [23:0] got_w [$];
  int          ack_cnt;

  always @(posedge clk) begin
    if (rst) begin
      got.delete();
      got_w.delete();
      ack_cnt = 0;
    end else begin
      if (bus.out_valid && bus.out_ready && !bus.redirect) got.push_back({bus.out_pc, bus.out_data});
      if (bus_w.out_valid && bus_w.out_ready) got_w.push_back({bus_w.out_pc, bus_w.out_data});
      if (bus.mem_req && bus.mem_ack) ack_cnt = ack_cnt + 1;
    end
  end

  int n_checks = 0;
  int n_fail   = 0;

  function automatic logic [23:0] q_at(input logic [23:0] q[$], input int i);
    if (i < q.size()) return q[i];
    return 24'hBADBAD;
  endfunction

  task automatic apply_reset(input logic ready);
    rst             = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 16'h0000;
    bus.out_ready   = ready;
    mem_en          = 1'b1;
    mem_lat         = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst             = 1'b1;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 16'h0000;
    bus.out_ready   = 1'b1;
    mem_en          = 1'b1;
    mem_lat         = 0;
    data_base       = 8'h30;
    repeat (2) @(negedge clk);
    n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL reset_mem_req: got %0h expected 0", bus.mem_req); end
    n_checks++; if (bus.mem_addr !== 16'h0000) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 0000", bus.mem_addr); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %0h expected 0", bus.out_valid); end
    n_checks++; if (bus.out_data !== 8'h00) begin n_fail++; $display("FAIL reset_out_data: got %h expected 00", bus.out_data); end
    n_checks++; if (bus.out_pc !== 16'h0000) begin n_fail++; $display("FAIL reset_out_pc: got %h expected 0000", bus.out_pc); end
    n_checks++; if (bus_w.mem_addr !== 16'hFFFE) begin n_fail++; $display("FAIL reset_mem_addr_w: got %h expected fffe", bus_w.mem_addr); end
    n_checks++; if (bus_w.out_pc !== 16'h0000) begin n_fail++; $display("FAIL reset_out_pc_w: got %h expected 0000", bus_w.out_pc); end
  endtask

  task automatic test_stream();
    logic [23:0] exp;
    data_base = 8'h30;
    apply_reset(1'b1);
    // Posedges E0..E9: issue at E0, first push at E1, pops E2..E9
    repeat (10) @(posedge clk);
    #1;
    n_checks++; if (got.size() !== 8) begin n_fail++; $display("FAIL stream_count: got %0d expected 8", got.size()); end
    for (int i = 0; i < 8; i++) begin
      exp = {16'(i), 8'h30 + 8'(i)};
      n_checks++; if (q_at(got, i) !== exp) begin n_fail++; $display("FAIL stream_entry%0d: got %h expected %h", i, q_at(got, i), exp); end
    end
  endtask

  task automatic test_back_pressure();
    logic [23:0] exp;
    data_base = 8'hA0;
    apply_reset(1'b0);
    repeat (10) @(negedge clk);
    n_checks++; if (bus.out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_out_valid: got %0h expected 1", bus.out_valid); end
    n_checks++; if (bus.out_pc !== 16'h0000) begin n_fail++; $display("FAIL bp_head_pc: got %h expected 0000", bus.out_pc); end
    n_checks++; if (bus.out_data !== 8'hA0) begin n_fail++; $display("FAIL bp_head_data: got %h expected a0", bus.out_data); end
    n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL bp_mem_req: got %0h expected 0", bus.mem_req); end
    n_checks++; if (ack_cnt !== 4) begin n_fail++; $display("FAIL bp_acks: got %0d expected 4", ack_cnt); end
    bus.out_ready = 1'b1;
    for (int k = 0; k < 40 && got.size() < 6; k++) @(negedge clk);
    n_checks++; if (got.size() < 6) begin n_fail++; $display("FAIL bp_drain_timeout: got %0d entries expected >=6", got.size()); end
    for (int i = 0; i < 5; i++) begin
      exp = {16'(i), 8'hA0 + 8'(i)};
      n_checks++; if (q_at(got, i) !== exp) begin n_fail++; $display("FAIL bp_entry%0d: got %h expected %h", i, q_at(got, i), exp); end
    end
  endtask

  task automatic test_redirect_inflight();
    int idx;
    data_base = 8'h30;
    apply_reset(1'b1);
    for (int k = 0; k < 40 && !(bus.mem_req && bus.mem_addr == 16'h0005); k++) @(negedge clk);
    n_checks++; if (!(bus.mem_req === 1'b1 && bus.mem_addr === 16'h0005)) begin n_fail++; $display("FAIL rdi_reach_pc5: got addr %h expected 0005", bus.mem_addr); end
    mem_en          = 1'b0;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0100;
    @(negedge clk);
    bus.redirect = 1'b0;
    idx = got.size();
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rdi_out_valid: got %0h expected 0", bus.out_valid); end
    n_checks++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL rdi_req_held: got %0h expected 1", bus.mem_req); end
    n_checks++; if (bus.mem_addr !== 16'h0005) begin n_fail++; $display("FAIL rdi_addr_held: got %h expected 0005", bus.mem_addr); end
    repeat (2) @(negedge clk);
    n_checks++; if (bus.mem_addr !== 16'h0005) begin n_fail++; $display("FAIL rdi_addr_held2: got %h expected 0005", bus.mem_addr); end
    mem_en = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL rdi_new_req: got %0h expected 1", bus.mem_req); end
    n_checks++; if (bus.mem_addr !== 16'h0100) begin n_fail++; $display("FAIL rdi_new_addr: got %h expected 0100", bus.mem_addr); end
    for (int k = 0; k < 40 && got.size() < idx + 2; k++) @(negedge clk);
    n_checks++; if (q_at(got, idx) !== {16'h0100, 8'h30}) begin n_fail++; $display("FAIL rdi_first_out: got %h expected 010030", q_at(got, idx)); end
    n_checks++; if (q_at(got, idx + 1) !== {16'h0101, 8'h31}) begin n_fail++; $display("FAIL rdi_second_out: got %h expected 010131", q_at(got, idx + 1)); end
  endtask

  task automatic test_redirect_with_ack();
    data_base = 8'h50;
    apply_reset(1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.out_pc !== 16'h0000) begin n_fail++; $display("FAIL rda_pre_head: got %h expected 0000", bus.out_pc); end
    n_checks++; if (bus.mem_addr !== 16'h0002) begin n_fail++; $display("FAIL rda_pre_addr: got %h expected 0002", bus.mem_addr); end
    n_checks++; if (bus.mem_ack !== 1'b1) begin n_fail++; $display("FAIL rda_pre_ack: got %0h expected 1", bus.mem_ack); end
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h0200;
    bus.out_ready   = 1'b1;
    @(negedge clk);
    bus.redirect = 1'b0;
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL rda_out_valid: got %0h expected 0", bus.out_valid); end
    n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL rda_idle_req: got %0h expected 0", bus.mem_req); end
    n_checks++; if (got.size() !== 0) begin n_fail++; $display("FAIL rda_no_pop: got %0d pops expected 0", got.size()); end
    @(negedge clk);
    n_checks++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL rda_new_req: got %0h expected 1", bus.mem_req); end
    n_checks++; if (bus.mem_addr !== 16'h0200) begin n_fail++; $display("FAIL rda_new_addr: got %h expected 0200", bus.mem_addr); end
    for (int k = 0; k < 40 && got.size() < 1; k++) @(negedge clk);
    n_checks++; if (q_at(got, 0) !== {16'h0200, 8'h50}) begin n_fail++; $display("FAIL rda_first_out: got %h expected 020050", q_at(got, 0)); end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_pc [4];
    exp_pc = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    apply_reset(1'b1);
    for (int k = 0; k < 40 && got_w.size() < 4; k++) @(negedge clk);
    n_checks++; if (got_w.size() < 4) begin n_fail++; $display("FAIL wrap_timeout: got %0d entries expected >=4", got_w.size()); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (q_at(got_w, i) !== {exp_pc[i], exp_pc[i][7:0]}) begin n_fail++; $display("FAIL wrap_entry%0d: got %h expected %h", i, q_at(got_w, i), {exp_pc[i], exp_pc[i][7:0]}); end
    end
  endtask

  task automatic test_async_reset();
    data_base = 8'h70;
    apply_reset(1'b0);
    repeat (4) @(posedge clk);
    @(negedge clk);
    n_checks++; if (bus.out_data !== 8'h70) begin n_fail++; $display("FAIL ar_pre_head: got %h expected 70", bus.out_data); end
    n_checks++; if (bus.mem_addr !== 16'h0003) begin n_fail++; $display("FAIL ar_pre_addr: got %h expected 0003", bus.mem_addr); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL ar_mem_req: got %0h expected 0", bus.mem_req); end
    n_checks++; if (bus.mem_addr !== 16'h0000) begin n_fail++; $display("FAIL ar_mem_addr: got %h expected 0000", bus.mem_addr); end
    n_checks++; if (bus.out_valid !== 1'b0) begin n_fail++; $display("FAIL ar_out_valid: got %0h expected 0", bus.out_valid); end
    n_checks++; if (bus.out_data !== 8'h00) begin n_fail++; $display("FAIL ar_out_data: got %h expected 00", bus.out_data); end
    n_checks++; if (bus.out_pc !== 16'h0000) begin n_fail++; $display("FAIL ar_out_pc: got %h expected 0000", bus.out_pc); end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (bus.mem_req !== 1'b1) begin n_fail++; $display("FAIL ar_restart_req: got %0h expected 1", bus.mem_req); end
    n_checks++; if (bus.mem_addr !== 16'h0000) begin n_fail++; $display("FAIL ar_restart_addr: got %h expected 0000", bus.mem_addr); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_stream();
    test_back_pressure();
    test_redirect_inflight();
    test_redirect_with_ack();
    test_wrap();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
